// File: rtl/nla_pkg.sv
// Shared definitions for the nonlinear-approximation datapath:
// default widths, function encodings, end-of-series sentinel and streamer states.
package nla_pkg;

  localparam int NLA_DATA_WIDTH = 32;
  localparam int NLA_ADDR_LINES = 5;
  localparam int NLA_FUNC_BITS  = 2;

  localparam logic [31:0] SENTINEL_WORD = 32'h7F900000;

  localparam logic [NLA_FUNC_BITS-1:0] FN_TANH    = 2'd0;
  localparam logic [NLA_FUNC_BITS-1:0] FN_GELU    = 2'd1;
  localparam logic [NLA_FUNC_BITS-1:0] FN_SIGMOID = 2'd2;
  localparam logic [NLA_FUNC_BITS-1:0] FN_SPARE   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_SENTINEL
  } stream_state_t;

endpackage

// File: rtl/coeff_bank.sv
// Per-function coefficient tables and series lengths: synchronous write,
// combinational read. Table contents are deliberately left unreset.
module coeff_bank
  import nla_pkg::*;
#(
  parameter int DATA_WIDTH = NLA_DATA_WIDTH,
  parameter int ADDR_LINES = NLA_ADDR_LINES,
  parameter int FUNC_BITS  = NLA_FUNC_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [FUNC_BITS-1:0]  wr_func_i,
  input  logic [ADDR_LINES-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  len_we_i,
  input  logic [ADDR_LINES:0]   wr_len_i,
  input  logic [FUNC_BITS-1:0]  rd_func_i,
  input  logic [ADDR_LINES-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [ADDR_LINES:0]   rd_len_o
);

  localparam int NUM_FUNCS = 1 << FUNC_BITS;
  localparam int DEPTH     = 1 << ADDR_LINES;
  localparam logic [ADDR_LINES:0] MAX_LEN = {1'b1, {ADDR_LINES{1'b0}}};

  logic [DATA_WIDTH-1:0] mem_q [NUM_FUNCS][DEPTH];
  logic [ADDR_LINES:0]   len_q [NUM_FUNCS];
  logic [ADDR_LINES:0]   len_d [NUM_FUNCS];
  logic [ADDR_LINES:0]   len_clamped;

  // Lengths beyond the table depth saturate at a full table.
  always_comb begin
    len_clamped = (wr_len_i > MAX_LEN) ? MAX_LEN : wr_len_i;
    len_d = len_q;
    if (len_we_i) begin
      len_d[wr_func_i] = len_clamped;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_FUNCS; i++) begin
        len_q[i] <= '0;
      end
    end else begin
      len_q <= len_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_func_i][wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_func_i][rd_addr_i];
  assign rd_len_o  = len_q[rd_func_i];

endmodule

// File: rtl/coeff_streamer.sv
// Streams one function's coefficients highest order first, then the NaN
// sentinel, over valid/ready into the polynomial MAC's coefficient FIFO.
module coeff_streamer
  import nla_pkg::*;
#(
  parameter int                  DATA_WIDTH = NLA_DATA_WIDTH,
  parameter int                  ADDR_LINES = NLA_ADDR_LINES,
  parameter int                  FUNC_BITS  = NLA_FUNC_BITS,
  parameter logic [DATA_WIDTH-1:0] SENTINEL = SENTINEL_WORD
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_we_i,
  input  logic [FUNC_BITS-1:0]  cfg_func_i,
  input  logic [ADDR_LINES-1:0] cfg_addr_i,
  input  logic [DATA_WIDTH-1:0] cfg_data_i,
  input  logic                  cfg_len_we_i,
  input  logic [ADDR_LINES:0]   cfg_len_i,
  input  logic                  start_i,
  input  logic [FUNC_BITS-1:0]  func_sel_i,
  output logic [DATA_WIDTH-1:0] coeff_o,
  output logic                  coeff_valid_o,
  input  logic                  coeff_ready_i,
  output logic                  coeff_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  stream_state_t         state_q, state_d;
  logic [FUNC_BITS-1:0]  func_q, func_d;
  logic [ADDR_LINES-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] coeff_q, coeff_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [FUNC_BITS-1:0]  rd_func;
  logic [ADDR_LINES-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_LINES:0]   rd_len;
  logic [ADDR_LINES:0]   len_m1;
  logic                  xfer;

  coeff_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_LINES(ADDR_LINES),
    .FUNC_BITS (FUNC_BITS)
  ) u_bank (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en_i  (cfg_we_i & ~busy_q),
    .wr_func_i(cfg_func_i),
    .wr_addr_i(cfg_addr_i),
    .wr_data_i(cfg_data_i),
    .len_we_i (cfg_len_we_i & ~busy_q),
    .wr_len_i (cfg_len_i),
    .rd_func_i(rd_func),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data),
    .rd_len_o (rd_len)
  );

  // In IDLE the read port looks ahead at the top entry of the requested table;
  // while streaming it looks at the next-lower entry so a transfer can reload in one edge.
  assign len_m1  = rd_len - 1'b1;
  assign rd_func = (state_q == S_IDLE) ? func_sel_i : func_q;
  assign rd_addr = (state_q == S_IDLE) ? len_m1[ADDR_LINES-1:0] : idx_q - 1'b1;
  assign xfer    = valid_q & coeff_ready_i;

  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    idx_d   = idx_q;
    coeff_d = coeff_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (rd_len == '0) begin
            err_d = 1'b1;
          end else begin
            func_d  = func_sel_i;
            idx_d   = len_m1[ADDR_LINES-1:0];
            coeff_d = rd_data;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (xfer) begin
          if (idx_q != '0) begin
            idx_d   = idx_q - 1'b1;
            coeff_d = rd_data;
          end else begin
            coeff_d = SENTINEL;
            last_d  = 1'b1;
            state_d = S_SENTINEL;
          end
        end
      end
      S_SENTINEL: begin
        if (xfer) begin
          coeff_d = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      func_q  <= '0;
      idx_q   <= '0;
      coeff_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      idx_q   <= idx_d;
      coeff_q <= coeff_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign coeff_o       = coeff_q;
  assign coeff_valid_o = valid_q;
  assign coeff_last_o  = last_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule
